// File: rtl/alu_op_sequencer_if.sv
// Bus bundle for the ALU operation sequencer: command handshake, ALU drive/return,
// result handshake and status. The sequencer uses the slave view; its environment
// (command source, ALU, result consumer) uses the master view.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4,
    parameter int unsigned CNT_W = 16
) ();
    // command side
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_op;
    // ALU side
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    // result side
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    // status
    logic [3:0]       flags_q;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_flags, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_en, res_valid, res_data, res_err,
               flags_q, busy, op_count
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_flags, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_en, res_valid, res_data, res_err,
               flags_q, busy, op_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one command, pulses the shared ALU, waits its
// latency, captures result/flags and holds them until the consumer takes them.
// Illegal opcodes bypass the ALU and return an error result straight away.
module alu_op_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OPW     = 4,
    parameter int unsigned OP_MAX  = 9,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input logic            clk,
    input logic            rst,
    alu_op_sequencer_if.slave bus
);

    // A one-bit counter is still needed when ALU_LAT is 1 ($clog2(1) is 0).
    localparam int unsigned LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [OPW-1:0]   OpMax   = OPW'(OP_MAX);
    localparam logic [LAT_W-1:0] WaitTop = LAT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e           state_q;
    logic [LAT_W-1:0] wait_cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OPW-1:0]   alu_op_q;
    logic             alu_en_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_err_q;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] op_count_q;

    // Sequencing FSM; every bus output except cmd_ready/busy is a register here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            flags_q     <= '0;
            op_count_q  <= '0;
        end else begin
            // alu_en is a single-cycle pulse covering the ISSUE state only.
            alu_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        alu_a_q  <= bus.cmd_a;
                        alu_b_q  <= bus.cmd_b;
                        alu_op_q <= bus.cmd_op;
                        if (bus.cmd_op > OpMax) begin
                            // Error result skips the ALU; flags_q is left alone.
                            res_data_q  <= '0;
                            res_err_q   <= 1'b1;
                            res_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            alu_en_q <= 1'b1;
                            state_q  <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    wait_cnt_q <= WaitTop;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (wait_cnt_q == '0) begin
                        res_data_q  <= bus.alu_result;
                        flags_q     <= bus.alu_flags;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - LAT_W'(1);
                    end
                end
                StDone: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (!res_err_q) begin
                            op_count_q <= op_count_q + CNT_W'(1);
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status decoded from state; cmd_ready is also held low while reset is applied.
    assign bus.cmd_ready = (state_q == StIdle) && !rst;
    assign bus.busy      = (state_q != StIdle);

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_en    = alu_en_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.flags_q   = flags_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer. u1: ALU_LAT=1, CNT_W=4 (table, backpressure,
// counter wrap). u2: ALU_LAT=3 (latency / capture timing, reset mid-WAIT).
module tb_alu_op_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_op_sequencer_if #(.WIDTH(32), .OPW(4), .CNT_W(4))  if1 ();
    alu_op_sequencer_if #(.WIDTH(32), .OPW(4), .CNT_W(16)) if2 ();

    alu_op_sequencer #(.WIDTH(32), .OPW(4), .OP_MAX(9), .ALU_LAT(1), .CNT_W(4)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    alu_op_sequencer #(.WIDTH(32), .OPW(4), .OP_MAX(9), .ALU_LAT(3), .CNT_W(16)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] alu_res;
        logic [3:0]  alu_flags;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one command on u1 (LAT=1) through to handoff. Entered #1 after a posedge.
    task automatic do_op(input vec_t v);
        int n;
        if1.cmd_a      = v.a;
        if1.cmd_b      = v.b;
        if1.cmd_op     = v.op;
        if1.alu_result = v.alu_res;
        if1.alu_flags  = v.alu_flags;
        if1.cmd_valid  = 1'b1;
        check("ready_idle", if1.cmd_ready, 1);
        @(posedge clk); #1;
        if1.cmd_valid = 1'b0;
        check("busy_accept", if1.busy, 1);
        check("cmd_ready_busy", if1.cmd_ready, 0);
        check("alu_a", if1.alu_a, v.a);
        check("alu_b", if1.alu_b, v.b);
        check("alu_op", if1.alu_op, v.op);
        check("alu_en", if1.alu_en, !v.exp_err);
        n = 0;
        while (!if1.res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (v.exp_err) check("lat_illegal", n <= 1, 1);
        else           check("lat_legal", n, 2);
        check("res_data", if1.res_data, v.exp_data);
        check("res_err", if1.res_err, v.exp_err);
        check("flags_q", if1.flags_q, v.exp_flags);
        if1.res_ready = 1'b1;
        @(posedge clk); #1;
        if1.res_ready = 1'b0;
        check("res_valid_off", if1.res_valid, 0);
        check("ready_after", if1.cmd_ready, 1);
        check("op_count", if1.op_count, v.exp_cnt);
    endtask

    initial begin
        vec_t w;
        int   n;
        total = 0;
        bad   = 0;
        //             a             b    op     alu_res       flg    err  data          eflg   cnt
        vecs[0] = '{32'd5,        32'd3, 4'd0,  32'd8,        4'b0000, 1'b0, 32'd8,        4'b0000, 4'd1};
        vecs[1] = '{32'd7,        32'd7, 4'd1,  32'd0,        4'b1000, 1'b0, 32'd0,        4'b1000, 4'd2};
        vecs[2] = '{32'd1,        32'd2, 4'd15, 32'hdead,     4'b0111, 1'b1, 32'd0,        4'b1000, 4'd2};
        vecs[3] = '{32'd1,        32'd1, 4'd9,  32'hffffffff, 4'b0001, 1'b0, 32'hffffffff, 4'b0001, 4'd3};
        vecs[4] = '{32'd3,        32'd4, 4'd10, 32'h1234,     4'b1111, 1'b1, 32'd0,        4'b0001, 4'd3};
        vecs[5] = '{32'hffffffff, 32'd1, 4'd0,  32'd0,        4'b1100, 1'b0, 32'd0,        4'b1100, 4'd4};

        rst = 1'b1;
        if1.cmd_valid = 0; if1.cmd_a = 0; if1.cmd_b = 0; if1.cmd_op = 0;
        if1.alu_result = 0; if1.alu_flags = 0; if1.res_ready = 0;
        if2.cmd_valid = 0; if2.cmd_a = 0; if2.cmd_b = 0; if2.cmd_op = 0;
        if2.alu_result = 0; if2.alu_flags = 0; if2.res_ready = 0;

        // Reset state
        #1;
        check("rst_cmd_ready", if1.cmd_ready, 0);
        check("rst_busy", if1.busy, 0);
        check("rst_res_valid", if1.res_valid, 0);
        check("rst_op_count", if1.op_count, 0);
        check("rst_flags", if1.flags_q, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_cmd_ready", if1.cmd_ready, 1);
        check("rel_alu_en", if1.alu_en, 0);

        // Table of single operations on u1
        for (int i = 0; i < 6; i++) do_op(vecs[i]);

        // Backpressure: result held for 10 cycles, commands ignored meanwhile
        if1.cmd_a = 32'd2; if1.cmd_b = 32'd2; if1.cmd_op = 4'd0;
        if1.alu_result = 32'd4; if1.alu_flags = 4'b0000; if1.cmd_valid = 1'b1;
        @(posedge clk); #1;
        if1.cmd_valid = 1'b0;
        n = 0;
        while (!if1.res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_lat", n, 2);
        for (int i = 0; i < 10; i++) begin
            if1.cmd_valid  = 1'b1;
            if1.cmd_a      = 32'd99 + 32'(i);
            if1.cmd_op     = 4'd1;
            if1.alu_result = 32'hffff;
            @(posedge clk); #1;
            check("bp_valid", if1.res_valid, 1);
            check("bp_data", if1.res_data, 32'd4);
            check("bp_ready", if1.cmd_ready, 0);
            check("bp_alu_a", if1.alu_a, 32'd2);
        end
        // Handoff with a command pending: it must not be taken on the same edge
        if1.cmd_a = 32'd77;
        if1.res_ready = 1'b1;
        @(posedge clk); #1;
        if1.res_ready = 1'b0;
        if1.cmd_valid = 1'b0;
        check("bp_rel_valid", if1.res_valid, 0);
        check("bp_rel_ready", if1.cmd_ready, 1);
        check("bp_no_same_accept", if1.alu_a, 32'd2);
        check("bp_count", if1.op_count, 4'd5);
        // res_ready while idle does nothing
        if1.res_ready = 1'b1;
        @(posedge clk); #1;
        if1.res_ready = 1'b0;
        check("idle_rdy_count", if1.op_count, 4'd5);
        check("idle_rdy_busy", if1.busy, 0);

        // Counter wrap: 11 more legal ops take op_count 5 -> 15 -> 0
        for (int i = 0; i < 11; i++) begin
            w = '{32'(i), 32'd1, 4'd2, 32'(i + 100), 4'b0010, 1'b0, 32'(i + 100),
                  4'b0010, 4'((6 + i) & 15)};
            do_op(w);
        end
        check("wrap_zero", if1.op_count, 0);

        // ALU_LAT=3 on u2: capture must use the value present before edge N+4
        if2.cmd_a = 32'd10; if2.cmd_b = 32'd20; if2.cmd_op = 4'd2;
        if2.alu_result = 32'hbad00000; if2.alu_flags = 4'b1111; if2.cmd_valid = 1'b1;
        @(posedge clk); #1;                            // edge N
        if2.cmd_valid = 1'b0;
        check("l3_en_n", if2.alu_en, 1);
        check("l3_op", if2.alu_op, 4'd2);
        @(posedge clk); #1;                            // N+1
        check("l3_en_n1", if2.alu_en, 0);
        check("l3_busy", if2.busy, 1);
        @(posedge clk); #1;                            // N+2
        check("l3_en_n2", if2.alu_en, 0);
        check("l3_valid_n2", if2.res_valid, 0);
        @(posedge clk); #1;                            // N+3
        check("l3_valid_n3", if2.res_valid, 0);
        if2.alu_result = 32'h1234; if2.alu_flags = 4'b0010;
        @(posedge clk); #1;                            // N+4
        check("l3_valid_n4", if2.res_valid, 1);
        check("l3_data", if2.res_data, 32'h1234);
        check("l3_flags", if2.flags_q, 4'b0010);
        if2.alu_result = 32'hbad11111;
        @(posedge clk); #1;
        check("l3_data_hold", if2.res_data, 32'h1234);
        if2.res_ready = 1'b1;
        @(posedge clk); #1;
        if2.res_ready = 1'b0;
        check("l3_count", if2.op_count, 1);
        check("l3_ready", if2.cmd_ready, 1);

        // Reset in the middle of WAIT on u2 discards the operation
        if2.cmd_a = 32'd6; if2.cmd_op = 4'd3; if2.cmd_valid = 1'b1;
        @(posedge clk); #1;
        if2.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("pre_rst_busy", if2.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", if2.busy, 0);
        check("mid_rst_ready", if2.cmd_ready, 0);
        check("mid_rst_alu_a", if2.alu_a, 0);
        check("mid_rst_alu_op", if2.alu_op, 0);
        check("mid_rst_en", if2.alu_en, 0);
        check("mid_rst_valid", if2.res_valid, 0);
        check("mid_rst_data", if2.res_data, 0);
        check("mid_rst_flags", if2.flags_q, 0);
        check("mid_rst_count", if2.op_count, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", if2.res_valid, 0);
            check("post_rst_ready", if2.cmd_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
